// File: rtl/cpu6_instr_encoder.sv
// cpu6_instr_encoder
//   Packs RV32I instruction fields into 32-bit instruction words for the cpu6
//   self-test / debug instruction-injection path into fetch. Commands arrive on
//   a valid/ready port, are encoded combinationally, and are written into a
//   small FIFO. Encoded words leave on a valid/ready instruction port.
//
//   Illegal commands (unknown opcode or bad funct fields) are still accepted.
//   They are pushed as word 32'h0000_0000 with instr_err=1.
//
// Parameters
//   DEPTH  output FIFO entries (power of two, >= 2)
//   CNT_W  width of the accepted / illegal event counters
//
// Ports
//   clk, reset    core clock; synchronous active-high reset
//   flush         synchronous FIFO clear; counters are kept
//   cmd_*         command port: valid/ready handshake plus the opcode, funct3,
//                 funct7, rd, rs1, rs2 and imm fields
//   instr_valid   FIFO not empty
//   instr_ready   consumer takes the head word
//   instr         head word
//   instr_err     head word flagged illegal
//   enc_cnt       commands accepted since reset (saturating)
//   err_cnt       accepted commands flagged illegal (saturating)
//
// Build option
//   CPU6_ENC_RANGECHK_EN  when defined, immediates that do not fit their
//                         encoding field are also flagged illegal. When it is
//                         undefined, immediates are truncated silently.

`default_nettype none

module cpu6_instr_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_opcode,
  input  logic [2:0]       cmd_funct3,
  input  logic [6:0]       cmd_funct7,
  input  logic [4:0]       cmd_rd,
  input  logic [4:0]       cmd_rs1,
  input  logic [4:0]       cmd_rs2,
  input  logic [31:0]      cmd_imm,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic             instr_err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage: command encode (combinational from the command fields)
  logic signed [31:0] w_imm;
  logic               w_is_shift;
  logic [31:0]        w_word;
  logic               w_fn_err;
  logic               w_rng_err;
  logic               w_bad;
  logic [31:0]        w_enc;
  logic               w_unused;

  assign w_imm      = cmd_imm;
  assign w_is_shift = (cmd_opcode == OP_IMM) &&
                      ((cmd_funct3 == 3'b001) || (cmd_funct3 == 3'b101));
  assign w_unused   = &{1'b0, w_imm[31:21]};

  always_comb begin
    w_word   = '0;
    w_fn_err = 1'b0;
    case (cmd_opcode)
      OP_R: begin
        w_word   = {cmd_funct7, cmd_rs2, cmd_rs1, cmd_funct3, cmd_rd, cmd_opcode};
        // funct7 0x20 only selects sub / sra
        w_fn_err = !((cmd_funct7 == 7'h00) ||
                     ((cmd_funct7 == 7'h20) &&
                      ((cmd_funct3 == 3'd0) || (cmd_funct3 == 3'd5))));
      end
      OP_LOAD, OP_IMM, OP_JALR, OP_SYS: begin
        w_word = {w_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, cmd_opcode};
        // Shift immediates take their upper seven bits from funct7
        if (w_is_shift) w_word[31:20] = {cmd_funct7, w_imm[4:0]};
        if (cmd_opcode == OP_LOAD)
          w_fn_err = (cmd_funct3 == 3'd3) || (cmd_funct3 == 3'd6) || (cmd_funct3 == 3'd7);
        else if (cmd_opcode == OP_JALR)
          w_fn_err = (cmd_funct3 != 3'd0);
        else if (cmd_opcode == OP_SYS)
          w_fn_err = (cmd_funct3 == 3'd4);
      end
      OP_STORE: begin
        w_word   = {w_imm[11:5], cmd_rs2, cmd_rs1, cmd_funct3, w_imm[4:0], cmd_opcode};
        w_fn_err = (cmd_funct3 > 3'd2);
      end
      OP_BRANCH: begin
        w_word   = {w_imm[12], w_imm[10:5], cmd_rs2, cmd_rs1, cmd_funct3,
                    w_imm[4:1], w_imm[11], cmd_opcode};
        w_fn_err = (cmd_funct3 == 3'd2) || (cmd_funct3 == 3'd3);
      end
      OP_LUI, OP_AUIPC: begin
        w_word = {w_imm[19:0], cmd_rd, cmd_opcode};
      end
      OP_JAL: begin
        w_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], cmd_rd, cmd_opcode};
      end
      default: w_fn_err = 1'b1;
    endcase
  end

`ifdef CPU6_ENC_RANGECHK_EN
  always_comb begin
    w_rng_err = 1'b0;
    case (cmd_opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYS, OP_STORE:
        w_rng_err = w_is_shift ? (w_imm[31:5] != '0)
                               : (w_imm[31:11] != {21{w_imm[11]}});
      OP_BRANCH:        w_rng_err = (w_imm[31:12] != {20{w_imm[12]}}) || w_imm[0];
      OP_JAL:           w_rng_err = (w_imm[31:20] != {12{w_imm[20]}}) || w_imm[0];
      OP_LUI, OP_AUIPC: w_rng_err = (w_imm[31:20] != '0);
      default:          w_rng_err = 1'b0;
    endcase
  end
`else
  assign w_rng_err = 1'b0;
`endif

  assign w_bad = w_fn_err | w_rng_err;
  assign w_enc = w_bad ? 32'h0000_0000 : w_word;

  // Stage: output FIFO
  logic [32:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [OW-1:0]  r_occ;
  logic [32:0]    r_last;
  logic [CNT_W-1:0] r_enc_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic [32:0]    w_head;

  assign w_full  = (r_occ == OW'(DEPTH));
  assign w_empty = (r_occ == '0);
  assign w_push  = cmd_valid & cmd_ready;
  assign w_pop   = instr_valid & instr_ready;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      r_enc_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      // A command accepted during flush is dropped from the FIFO but still counted
      if (w_push) begin
        r_enc_cnt <= sat_inc(r_enc_cnt);
        if (w_bad) r_err_cnt <= sat_inc(r_err_cnt);
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_occ    <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_occ <= r_occ + OW'(w_push) - OW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= {w_bad, w_enc};
  end

  // Keeps the last presented head so instr/instr_err stay stable while empty
  always_ff @(posedge clk) begin
    if (reset)         r_last <= '0;
    else if (!w_empty) r_last <= w_head;
  end

  assign cmd_ready          = !w_full;
  assign instr_valid        = !w_empty;
  assign {instr_err, instr} = w_empty ? r_last : w_head;
  assign enc_cnt            = r_enc_cnt;
  assign err_cnt            = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cpu6_instr_encoder.sv
// Scoreboard bench for cpu6_instr_encoder: the driver pushes the expected
// {err, word} for every accepted command, and the monitor pops and compares
// each word the DUT hands over.
`timescale 1ns/1ps

module tb_cpu6_instr_encoder;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [6:0]       cmd_opcode;
  logic [2:0]       cmd_funct3;
  logic [6:0]       cmd_funct7;
  logic [4:0]       cmd_rd;
  logic [4:0]       cmd_rs1;
  logic [4:0]       cmd_rs2;
  logic [31:0]      cmd_imm;
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic             instr_err;
  logic [CNT_W-1:0] enc_cnt;
  logic [CNT_W-1:0] err_cnt;

  cpu6_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_funct3(cmd_funct3), .cmd_funct7(cmd_funct7),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_err(instr_err),
    .enc_cnt(enc_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acc = 0;
  int          n_errs = 0;
  int          cyc = 0;
  logic [32:0] sb[$];
  logic [32:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next posedge when valid & ready hold now
  always @(negedge clk) begin
    if (!reset && !flush && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got 0x%08h err %0d, want no word", instr, instr_err);
      end else begin
        mon_exp = sb.pop_front();
        check("word", instr, mon_exp[31:0]);
        check("word_err", {31'b0, instr_err}, {31'b0, mon_exp[32]});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic e_err, input logic [31:0] e_word);
    bit acc;
    acc = 1'b0;
    cmd_opcode = op; cmd_funct3 = f3; cmd_funct7 = f7;
    cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        sb.push_back({e_err, e_word});
        acc = 1'b1;
        n_acc++;
        if (e_err) n_errs++;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: cmd_ready stayed 0, want 1");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int c0;
    reset = 1'b1; flush = 1'b0; cmd_valid = 1'b0; instr_ready = 1'b1;
    cmd_opcode = '0; cmd_funct3 = '0; cmd_funct7 = '0;
    cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_err", {31'b0, instr_err}, 32'd0);
    check("rst_enc_cnt", 32'(enc_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // T3: fill with the consumer stalled, then release exactly one word
    instr_ready = 1'b0;
    send(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 32'h0010_0093);
    send(7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, 32'h0020_0113);
    @(negedge clk);
    check("full_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("full_enc_cnt", 32'(enc_cnt), 32'(DEPTH));
    cmd_opcode = 7'h13; cmd_rd = 5'd3; cmd_imm = 32'd3; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("full_hold_enc_cnt", 32'(enc_cnt), 32'(DEPTH));
    @(posedge clk); #1;
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    @(negedge clk);
    check("pop_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("pop_one_left", {31'b0, instr_valid}, 32'd1);
    @(posedge clk); #1;
    instr_ready = 1'b1;
    drain();

    // T1: latency
    send(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093);
    @(negedge clk);
    check("t1_valid_next", {31'b0, instr_valid}, 32'd1);
    @(posedge clk); #1;

    // T2 and other legal formats
    send(7'h23, 3'd2, 7'h00, 5'd0, 5'd3, 5'd2, 32'd8, 1'b0, 32'h0021_A423);
    send(7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h0001_2345, 1'b0, 32'h1234_52B7);
    send(7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h4020_81B3);
    send(7'h13, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd3, 1'b0, 32'h0030_9093);
    send(7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'd3, 1'b0, 32'h4030_D093);
    send(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0, 32'hFE20_8EE3);
    send(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0010_00EF);
    send(7'h73, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0000_0073);

    // T4: odd branch offset
`ifdef CPU6_ENC_RANGECHK_EN
    send(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd3, 1'b1, 32'h0000_0000);
`else
    send(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd3, 1'b0, 32'h0000_0163);
`endif

    // T5: illegal opcode / funct combinations
    send(7'h7F, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd1, 1'b1, 32'h0000_0000);
    send(7'h03, 3'd3, 7'h00, 5'd1, 5'd2, 5'd0, 32'd0, 1'b1, 32'h0000_0000);
    send(7'h33, 3'd1, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 32'h0000_0000);
    send(7'h33, 3'd0, 7'h01, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 32'h0000_0000);
    send(7'h63, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4, 1'b1, 32'h0000_0000);
    send(7'h23, 3'd3, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4, 1'b1, 32'h0000_0000);
    send(7'h67, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 32'd0, 1'b1, 32'h0000_0000);
    send(7'h73, 3'd4, 7'h00, 5'd1, 5'd2, 5'd0, 32'd0, 1'b1, 32'h0000_0000);
    drain();
    @(negedge clk);
    check("enc_cnt", 32'(enc_cnt), 32'(n_acc));
    check("err_cnt", 32'(err_cnt), 32'(n_errs));
    @(posedge clk); #1;

    // Full throughput: addi x(i%32), x0, i every cycle
    c0 = cyc;
    for (int i = 0; i < 100; i++)
      send(7'h13, 3'd0, 7'h00, 5'(i), 5'd0, 5'd0, 32'(i), 1'b0,
           (32'(i) << 20) | (32'(i % 32) << 7) | 32'h13);
    check("throughput_cycles", 32'(cyc - c0), 32'd100);
    drain();

    // T6: flush with two entries queued
    instr_ready = 1'b0;
    send(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 32'h0010_0093);
    send(7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, 32'h0020_0113);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_valid", {31'b0, instr_valid}, 32'd0);
    check("flush_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("flush_enc_kept", 32'(enc_cnt), 32'(n_acc));
    @(posedge clk); #1;

    // Flush with a same-cycle accept: dropped but counted
    send(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 32'h0010_0093);
    flush = 1'b1;
    cmd_opcode = 7'h13; cmd_funct3 = 3'd0; cmd_rd = 5'd4; cmd_imm = 32'd4;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    cmd_valid = 1'b0;
    sb.delete();
    n_acc++;
    @(negedge clk);
    check("flush_acc_valid", {31'b0, instr_valid}, 32'd0);
    check("flush_acc_counted", 32'(enc_cnt), 32'(n_acc));
    @(posedge clk); #1;

    // T6: reset with two entries queued
    send(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 32'h0010_0093);
    send(7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 32'h0000_0000);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst2_valid", {31'b0, instr_valid}, 32'd0);
    check("rst2_instr", instr, 32'd0);
    check("rst2_enc_cnt", 32'(enc_cnt), 32'd0);
    check("rst2_err_cnt", 32'(err_cnt), 32'd0);
    check("rst2_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    instr_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end
endmodule
